// File: rtl/eth_pkg.sv
// Shared Ethernet receive definitions: CRC-32 constants, frame limits,
// the FCS checker FSM states and the end-of-frame status payload.
package eth_pkg;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

  localparam int unsigned ETH_FCS_BYTES       = 4;
  localparam int unsigned ETH_MIN_FRAME_BYTES = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } fcs_state_t;

  // End-of-frame verdict and error flags, latched together at out_done.
  typedef struct packed {
    logic fcs_ok;
    logic runt;
    logic align;
    logic oversize;
  } eof_status_t;

  // One bit-step of the reflected CRC-32 (register not inverted).
  function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic bit_in);
    logic [31:0] shifted;
    shifted = {1'b0, crc[31:1]};
    return (crc[0] ^ bit_in) ? (shifted ^ CRC32_POLY_REFL) : shifted;
  endfunction

endpackage

// File: rtl/crc32_dibit.sv
// Combinational reflected CRC-32 advance by one RMII dibit (bit 0 first).
module crc32_dibit
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [1:0]  dibit,
  output logic [31:0] crc_out
);

  logic [31:0] crc_mid;

  // Two serial bit-steps, earlier wire bit first.
  always_comb begin
    crc_mid = crc32_step(crc_in, dibit[0]);
    crc_out = crc32_step(crc_mid, dibit[1]);
  end

endmodule

// File: rtl/eth_rx_fcs_check.sv
// RMII receive FCS checker: assembles dibits into bytes, runs CRC-32 over the
// whole frame, forwards payload with the 4 FCS bytes held back and stripped,
// then pulses out_done with length, verdict and error flags.
// Optional build macro ETH_RX_FCS_STATS_EN adds good/bad frame counters.
module eth_rx_fcs_check
  import eth_pkg::*;
#(
  parameter int unsigned MAX_FRAME_BYTES = 1518,
  parameter int unsigned LEN_W           = 11
`ifdef ETH_RX_FCS_STATS_EN
  ,
  parameter int unsigned STAT_W          = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_axi_valid,
  input  logic [1:0]       rx_axi_data,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_done,
  output logic             out_fcs_ok,
  output logic [LEN_W-1:0] out_len,
  output logic             out_err_runt,
  output logic             out_err_align,
  output logic             out_err_oversize
`ifdef ETH_RX_FCS_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_good,
  output logic [STAT_W-1:0] stat_bad
`endif
);

  localparam int unsigned CNT_W = $clog2(MAX_FRAME_BYTES + 2);
  localparam logic [CNT_W-1:0] MAX_BYTES_C = CNT_W'(MAX_FRAME_BYTES);
  localparam logic [CNT_W-1:0] FCS_BYTES_C = CNT_W'(ETH_FCS_BYTES);
  localparam logic [CNT_W-1:0] MIN_BYTES_C = CNT_W'(ETH_MIN_FRAME_BYTES);
  localparam logic [LEN_W-1:0] MAX_LEN_C   = LEN_W'(MAX_FRAME_BYTES - ETH_FCS_BYTES);

  fcs_state_t       state_q, state_d;

  logic [1:0]       phase_q, phase_d;
  logic [5:0]       asm_q, asm_d;
  logic [31:0]      crc_q, crc_d;
  logic [CNT_W-1:0] nbytes_q, nbytes_d;
  logic [LEN_W-1:0] len_cnt_q, len_cnt_d;
  logic             ovs_q, ovs_d;
  logic [3:0][7:0]  hold_q, hold_d;

  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_done_q, out_done_d;
  logic [LEN_W-1:0] out_len_q, out_len_d;
  eof_status_t      status_q, status_d;

`ifdef ETH_RX_FCS_STATS_EN
  logic [STAT_W-1:0] stat_good_q, stat_good_d;
  logic [STAT_W-1:0] stat_bad_q, stat_bad_d;
`endif

  logic             start_c;
  logic             eof_c;
  logic [31:0]      crc_base_c;
  logic [31:0]      crc_next_c;

  // A valid dibit outside RECV opens a new frame; the first idle dibit in RECV closes it.
  assign start_c    = rx_axi_valid && (state_q != RECV);
  assign eof_c      = (state_q == RECV) && !rx_axi_valid;
  assign crc_base_c = start_c ? CRC32_INIT : crc_q;

  crc32_dibit u_crc (
    .crc_in  (crc_base_c),
    .dibit   (rx_axi_data),
    .crc_out (crc_next_c)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rx_axi_valid) state_d = RECV;
      RECV:    if (!rx_axi_valid) state_d = DONE;
      DONE:    state_d = rx_axi_valid ? RECV : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values: byte assembly, holdback, counters, verdict.
  always_comb begin
    logic [1:0]       phase_base;
    logic [CNT_W-1:0] nbytes_base;
    logic [LEN_W-1:0] len_base;
    logic             ovs_base;
    logic [7:0]       byte_c;
    logic             runt_c;
    logic             align_c;
    logic             ok_c;

    phase_d     = phase_q;
    asm_d       = asm_q;
    crc_d       = crc_q;
    nbytes_d    = nbytes_q;
    len_cnt_d   = len_cnt_q;
    ovs_d       = ovs_q;
    hold_d      = hold_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_done_d  = 1'b0;
    out_len_d   = out_len_q;
    status_d    = status_q;
`ifdef ETH_RX_FCS_STATS_EN
    stat_good_d = stat_good_q;
    stat_bad_d  = stat_bad_q;
`endif

    phase_base  = start_c ? 2'd0 : phase_q;
    nbytes_base = start_c ? '0 : nbytes_q;
    len_base    = start_c ? '0 : len_cnt_q;
    ovs_base    = start_c ? 1'b0 : ovs_q;
    byte_c      = {rx_axi_data, asm_q};
    runt_c      = nbytes_q < MIN_BYTES_C;
    align_c     = phase_q != 2'd0;
    ok_c        = (crc_q == CRC32_RESIDUE) && !runt_c && !align_c && !ovs_q;

    if (rx_axi_valid) begin
      crc_d     = crc_next_c;
      phase_d   = phase_base + 2'd1;
      nbytes_d  = nbytes_base;
      len_cnt_d = len_base;
      ovs_d     = ovs_base;
      case (phase_base)
        2'd0:    asm_d[1:0] = rx_axi_data;
        2'd1:    asm_d[3:2] = rx_axi_data;
        2'd2:    asm_d[5:4] = rx_axi_data;
        default: begin
          // Byte complete: count it, push it into the holdback, release the oldest.
          hold_d = {hold_q[2:0], byte_c};
          if (nbytes_base <= MAX_BYTES_C) begin
            nbytes_d = nbytes_base + CNT_W'(1);
          end
          if (nbytes_base >= MAX_BYTES_C) begin
            ovs_d = 1'b1;
          end else if (nbytes_base >= FCS_BYTES_C) begin
            out_valid_d = 1'b1;
            out_data_d  = hold_q[3];
            if (len_base < MAX_LEN_C) begin
              len_cnt_d = len_base + LEN_W'(1);
            end
          end
        end
      endcase
    end

    if (eof_c) begin
      out_done_d        = 1'b1;
      out_len_d         = len_cnt_q;
      status_d.fcs_ok   = ok_c;
      status_d.runt     = runt_c;
      status_d.align    = align_c;
      status_d.oversize = ovs_q;
`ifdef ETH_RX_FCS_STATS_EN
      if (ok_c) begin
        if (stat_good_q != '1) stat_good_d = stat_good_q + STAT_W'(1);
      end else begin
        if (stat_bad_q != '1) stat_bad_d = stat_bad_q + STAT_W'(1);
      end
`endif
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q     <= 2'd0;
      asm_q       <= '0;
      crc_q       <= CRC32_INIT;
      nbytes_q    <= '0;
      len_cnt_q   <= '0;
      ovs_q       <= 1'b0;
      hold_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_done_q  <= 1'b0;
      out_len_q   <= '0;
      status_q    <= '0;
`ifdef ETH_RX_FCS_STATS_EN
      stat_good_q <= '0;
      stat_bad_q  <= '0;
`endif
    end else begin
      phase_q     <= phase_d;
      asm_q       <= asm_d;
      crc_q       <= crc_d;
      nbytes_q    <= nbytes_d;
      len_cnt_q   <= len_cnt_d;
      ovs_q       <= ovs_d;
      hold_q      <= hold_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_done_q  <= out_done_d;
      out_len_q   <= out_len_d;
      status_q    <= status_d;
`ifdef ETH_RX_FCS_STATS_EN
      stat_good_q <= stat_good_d;
      stat_bad_q  <= stat_bad_d;
`endif
    end
  end

  assign out_valid        = out_valid_q;
  assign out_data         = out_data_q;
  assign out_done         = out_done_q;
  assign out_len          = out_len_q;
  assign out_fcs_ok       = status_q.fcs_ok;
  assign out_err_runt     = status_q.runt;
  assign out_err_align    = status_q.align;
  assign out_err_oversize = status_q.oversize;
`ifdef ETH_RX_FCS_STATS_EN
  assign stat_good        = stat_good_q;
  assign stat_bad         = stat_bad_q;
`endif

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Directed bench for eth_rx_fcs_check: table of frames plus back-to-back
// and mid-frame reset sequences.
module tb_eth_rx_fcs_check;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_axi_valid;
  logic [1:0]  rx_axi_data;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_done;
  logic        out_fcs_ok;
  logic [10:0] out_len;
  logic        out_err_runt;
  logic        out_err_align;
  logic        out_err_oversize;
`ifdef ETH_RX_FCS_STATS_EN
  logic [15:0] stat_good;
  logic [15:0] stat_bad;
`endif

  eth_rx_fcs_check dut (
    .clk              (clk),
    .rst              (rst),
    .rx_axi_valid     (rx_axi_valid),
    .rx_axi_data      (rx_axi_data),
    .out_valid        (out_valid),
    .out_data         (out_data),
    .out_done         (out_done),
    .out_fcs_ok       (out_fcs_ok),
    .out_len          (out_len),
    .out_err_runt     (out_err_runt),
    .out_err_align    (out_err_align),
    .out_err_oversize (out_err_oversize)
`ifdef ETH_RX_FCS_STATS_EN
    ,
    .stat_good        (stat_good),
    .stat_bad         (stat_bad)
`endif
  );

  always #10 clk = ~clk;

  typedef struct {
    string       name;
    int          nbytes;
    int          extra;
    bit          known;
    bit          fcs;
    bit          flip;
    bit          exp_ok;
    int          exp_len;
    bit          exp_runt;
    bit          exp_align;
    bit          exp_ovs;
  } vec_t;

  int errors = 0;
  int checks = 0;

  logic [7:0] got_q[$];
  int         done_seen;
  int         overlap;
  logic       cap_ok, cap_runt, cap_align, cap_ovs;
  logic [10:0] cap_len;
  int         exp_good = 0;
  int         exp_bad  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  function automatic vec_t mk(string n, int nb, int ex, bit kn, bit fc, bit fl,
                              bit ok, int len, bit ru, bit al, bit ov);
    vec_t v;
    v.name = n; v.nbytes = nb; v.extra = ex; v.known = kn; v.fcs = fc; v.flip = fl;
    v.exp_ok = ok; v.exp_len = len; v.exp_runt = ru; v.exp_align = al; v.exp_ovs = ov;
    return v;
  endfunction

  // Standard bitwise Ethernet FCS of a byte list (final inversion applied).
  function automatic logic [31:0] fcs_of(input logic [7:0] b[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build_frame(input vec_t v, input int seed, output logic [7:0] fr[$]);
    logic [7:0]  q[$];
    logic [31:0] f;
    q = {};
    if (v.known) begin
      q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
            8'h26, 8'h39, 8'hF4, 8'hCB};
    end else if (v.fcs) begin
      for (int i = 0; i < v.nbytes - 4; i++) q.push_back(8'(i * 13 + seed * 7 + 5));
      f = fcs_of(q);
      for (int k = 0; k < 4; k++) q.push_back(f[8*k +: 8]);
    end else begin
      for (int i = 0; i < v.nbytes; i++) q.push_back(8'(i * 13 + seed * 7 + 5));
    end
    if (v.flip) q[4] = q[4] ^ 8'h01;
    fr = q;
  endtask

  // Drive inputs for one cycle, then sample outputs on the following falling edge.
  task automatic cycle(input logic v, input logic [1:0] d);
    rx_axi_valid = v;
    rx_axi_data  = d;
    @(negedge clk);
    if (out_valid === 1'b1) got_q.push_back(out_data);
    if (out_done === 1'b1) begin
      done_seen++;
      if (out_valid === 1'b1) overlap++;
      cap_ok = out_fcs_ok; cap_len = out_len; cap_runt = out_err_runt;
      cap_align = out_err_align; cap_ovs = out_err_oversize;
    end
  endtask

  task automatic send_frame(input logic [7:0] fr[$], input vec_t v);
    int mism;
    got_q.delete();
    done_seen = 0; overlap = 0;
    cap_ok = 0; cap_len = '0; cap_runt = 0; cap_align = 0; cap_ovs = 0;
    foreach (fr[i]) for (int k = 0; k < 4; k++) cycle(1'b1, fr[i][2*k +: 2]);
    for (int e = 0; e < v.extra; e++) cycle(1'b1, 2'(e + 1));
    chk($sformatf("%s early_done", v.name), done_seen, 0);
    cycle(1'b0, 2'b00);
    chk($sformatf("%s done_pulse", v.name), done_seen, 1);
    chk($sformatf("%s overlap", v.name), overlap, 0);
    chk($sformatf("%s byte_count", v.name), got_q.size(), v.exp_len);
    mism = 0;
    foreach (got_q[i]) if (i < fr.size() && got_q[i] !== fr[i]) mism++;
    chk($sformatf("%s bytes_intact", v.name), mism, 0);
    chk($sformatf("%s fcs_ok", v.name), cap_ok, v.exp_ok);
    chk($sformatf("%s len", v.name), cap_len, v.exp_len);
    chk($sformatf("%s runt", v.name), cap_runt, v.exp_runt);
    chk($sformatf("%s align", v.name), cap_align, v.exp_align);
    chk($sformatf("%s oversize", v.name), cap_ovs, v.exp_ovs);
    if (v.exp_ok) exp_good++; else exp_bad++;
`ifdef ETH_RX_FCS_STATS_EN
    chk($sformatf("%s stat_good", v.name), stat_good, exp_good);
    chk($sformatf("%s stat_bad", v.name), stat_bad, exp_bad);
`endif
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[11];
    vec_t       v;
    logic [7:0] fr[$];
    logic [7:0] fr2[$];

    //            name        nb  ex kn fc fl ok len  ru al ov
    vecs[0]  = mk("known",    13, 0, 1, 0, 0, 1, 9,    0, 0, 0);
    vecs[1]  = mk("corrupt",  13, 0, 1, 0, 1, 0, 9,    0, 0, 0);
    vecs[2]  = mk("runt3",     3, 0, 0, 0, 0, 0, 0,    1, 0, 0);
    vecs[3]  = mk("dibit17",   4, 1, 0, 0, 0, 0, 0,    1, 1, 0);
    vecs[4]  = mk("min5",      5, 0, 0, 1, 0, 1, 1,    0, 0, 0);
    vecs[5]  = mk("fcs_only",  4, 0, 0, 1, 0, 0, 0,    1, 0, 0);
    vecs[6]  = mk("good64",   64, 0, 0, 1, 0, 1, 60,   0, 0, 0);
    vecs[7]  = mk("align20",  20, 2, 0, 1, 0, 0, 16,   0, 1, 0);
    vecs[8]  = mk("max1518", 1518, 0, 0, 1, 0, 1, 1514, 0, 0, 0);
    vecs[9]  = mk("over1519", 1519, 0, 0, 1, 0, 0, 1514, 0, 0, 1);
    vecs[10] = mk("over1600", 1600, 0, 0, 0, 0, 0, 1514, 0, 0, 1);

    rst = 1'b1;
    rx_axi_valid = 1'b0;
    rx_axi_data  = 2'b00;
    repeat (2) @(negedge clk);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data", out_data, 0);
    chk("reset out_done", out_done, 0);
    chk("reset out_len", out_len, 0);
    chk("reset out_fcs_ok", out_fcs_ok, 0);
    chk("reset flags", {out_err_runt, out_err_align, out_err_oversize}, 0);
    rst = 1'b0;
    repeat (2) cycle(1'b0, 2'b00);

    for (int i = 0; i < 11; i++) begin
      build_frame(vecs[i], i, fr);
      send_frame(fr, vecs[i]);
      repeat (2) cycle(1'b0, 2'b00);
    end

    // Back-to-back: second frame starts in the out_done cycle of the first.
    v = mk("b2b_a", 64, 0, 0, 1, 0, 1, 60, 0, 0, 0);
    build_frame(v, 21, fr);
    send_frame(fr, v);
    v.name = "b2b_b";
    build_frame(v, 33, fr2);
    send_frame(fr2, v);
    repeat (2) cycle(1'b0, 2'b00);

    // Reset 30 bytes into a frame: outputs clear at once, no out_done follows.
    v = mk("post_rst", 64, 0, 0, 1, 0, 1, 60, 0, 0, 0);
    build_frame(v, 5, fr);
    for (int i = 0; i < 30; i++) for (int k = 0; k < 4; k++) cycle(1'b1, fr[i][2*k +: 2]);
    chk("pre_rst bytes_flowing", got_q.size() > 0, 1);
    rst = 1'b1;
    rx_axi_valid = 1'b0;
    #1;
    chk("mid_rst out_valid", out_valid, 0);
    chk("mid_rst out_data", out_data, 0);
    chk("mid_rst out_done", out_done, 0);
    chk("mid_rst out_len", out_len, 0);
    chk("mid_rst flags", {out_fcs_ok, out_err_runt, out_err_align, out_err_oversize}, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_good = 0;
    exp_bad  = 0;
    done_seen = 0;
    repeat (4) cycle(1'b0, 2'b00);
    chk("mid_rst no_done", done_seen, 0);
    send_frame(fr, v);
    repeat (2) cycle(1'b0, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eth_rx_fcs_check.md
Name: eth_rx_fcs_check

Overview:
- Sits between mac_rx and mac_rx_ifc.
- Consumes the RMII dibit stream from mac_rx and assembles it into bytes. Runs the Ethernet CRC-32 over every byte, including the FCS.
- Emits the frame bytes with the 4 FCS bytes stripped, then a one-cycle end-of-frame pulse carrying the length, the FCS verdict and error flags.
- This lets the echo path reject corrupt frames before they reach the rx packet buffer.

Parameters:
- MAX_FRAME_BYTES, 1518: largest accepted frame in bytes, FCS included.
- LEN_W, 11: width of the length output.
- STAT_W, 16: width of the statistics counters (optional feature only).

Ports:
- clk  in  1  system clock (50 MHz RMII refclk domain).
- rst  in  1  asynchronous, active-high reset.
- rx_axi_valid  in  1  dibit valid. A frame is a contiguous run of high cycles; the first low cycle ends it.
- rx_axi_data  in  2  dibit; bit 0 is the earlier bit on the wire (LSB-first).
- out_valid  out  1  one-cycle strobe per payload byte.
- out_data  out  8  payload byte; valid only while out_valid is high.
- out_done  out  1  one-cycle end-of-frame pulse.
- out_fcs_ok  out  1  frame good; valid with out_done.
- out_len  out  LEN_W  count of payload bytes emitted, FCS excluded; valid with out_done.
- out_err_runt  out  1  frame shorter than 5 bytes; valid with out_done.
- out_err_align  out  1  dibit count not a multiple of 4; valid with out_done.
- out_err_oversize  out  1  frame longer than MAX_FRAME_BYTES; valid with out_done.

Behaviour:
- Reset: asynchronous, active-high. All outputs go to 0, the FSM goes to IDLE, and the CRC register loads 32'hFFFFFFFF.
- FSM states: IDLE, RECV, DONE.
  - IDLE -> RECV on rx_axi_valid=1. That dibit is dibit 0 of the frame.
  - RECV -> DONE on rx_axi_valid=0.
  - DONE lasts exactly one cycle and drives out_done=1.
  - DONE -> RECV if rx_axi_valid=1 in that same cycle; that dibit starts a new frame with fresh CRC, counters and holdback. Otherwise DONE -> IDLE.
- Byte assembly: four dibits per byte, first dibit in bits [1:0].
- CRC update: reflected CRC-32, polynomial 32'hEDB88320. Each dibit advances the register two bit-steps: data bit 0 first, then bit 1.
- FCS holdback: completed bytes enter a 4-deep shift buffer. Once the buffer already holds 4 bytes, each newly completed byte pushes out the oldest, which is registered to out_data/out_valid on the next cycle.
  - Latency: byte k appears one cycle after byte k+4 completes.
  - The final 4 bytes (the FCS) are never emitted.
- Length: out_len counts emitted bytes, saturating at MAX_FRAME_BYTES-4.
- Oversize: once total bytes exceed MAX_FRAME_BYTES, emission stops, the oversize flag sets, and the CRC keeps running.
- Runt: fewer than 5 complete bytes means no bytes are emitted and out_err_runt=1.
- Align: leftover partial-byte dibits at the end set out_err_align=1. The partial byte is discarded and is not fed into the length.
- Verdict: out_fcs_ok = (crc == 32'hDEBB20E3) and no runt, align or oversize error.
- out_done timing: asserted the cycle after the first rx_axi_valid=0. It never overlaps the last out_valid; the last out_valid occurs at least one cycle earlier.
- Flag hold: out_len and the three error flags hold their values until the next out_done.
- Reset mid-frame: no out_done for the aborted frame, and the partial frame is discarded.

Optional Feature:
- Macro: ETH_RX_FCS_STATS_EN.
- Defined: adds two outputs.
  - stat_good (STAT_W): saturating count of out_done with out_fcs_ok=1.
  - stat_bad (STAT_W): saturating count of out_done with out_fcs_ok=0.
  - Both counters clear on rst.
- Undefined: the ports and counters do not exist.

Decomposition:
- Package eth_pkg holds:
  - CRC32_POLY_REFL, CRC32_INIT, CRC32_RESIDUE
  - ETH_FCS_BYTES = 4, ETH_MIN_FRAME_BYTES = 5
  - typedef enum fcs_state_t {IDLE, RECV, DONE}
- Sub-module crc32_dibit: combinational, crc_in[31:0] + dibit[1:0] -> crc_out[31:0]. Shared with the planned FCS generator on the tx side.

Test Plan:
- Known vector: send bytes "123456789" (31..39) followed by FCS 26 39 F4 CB. Expect 9 out_valid strobes with 31..39, then out_done with fcs_ok=1, len=9, all error flags 0.
- Corrupt FCS: same frame with bit 0 of byte 4 flipped. Expect 9 bytes still emitted, then out_done with fcs_ok=0, len=9.
- Runt and align:
  - 3-byte frame: no out_valid; out_done with runt=1, fcs_ok=0, len=0.
  - 17-dibit frame: align=1, fcs_ok=0.
- Oversize: 1600-byte frame. Expect exactly 1514 out_valid strobes, then oversize=1, len=1514, fcs_ok=0.
- Back-to-back: two valid 64-byte frames separated by one idle cycle. Expect two out_done pulses, both fcs_ok=1 and len=60, with bytes intact. With ETH_RX_FCS_STATS_EN, stat_good=2.
- Reset mid-frame: assert rst at byte 30 of a frame. Outputs go to 0 immediately and no out_done follows. The next good frame passes with fcs_ok=1.
